// File: rtl/pc_unit_pkg.sv
// Shared fetch-stage types: flag word, instruction layout, branch condition codes
// and the condition evaluator used by the program-counter unit.
package pc_unit_pkg;

  typedef struct packed {
    logic z;
    logic s;
    logic o;
    logic c;
  } csr_t;

  // op[3:1] == 3'b010 marks a branch; {op[0], cc[2:0]} is its condition code.
  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  cc;
    logic        imm_valid;
    logic [22:0] body;
  } instr_t;

  typedef enum logic [3:0] {
    COND_AL   = 4'h0,
    COND_Z    = 4'h1,
    COND_NZ   = 4'h2,
    COND_GE   = 4'h3,
    COND_ZLT  = 4'h4,
    COND_GT   = 4'h5,
    COND_LT   = 4'h6,
    COND_V    = 4'h7,
    COND_BUSY = 4'h8,
    COND_MI   = 4'h9,
    COND_PL   = 4'hA,
    COND_NC   = 4'hB,
    COND_LS   = 4'hC,
    COND_HI   = 4'hD,
    COND_CS   = 4'hE,
    COND_NV   = 4'hF
  } cond_t;

  function automatic logic cond_eval(cond_t code, csr_t f, logic busy);
    logic ok;
    case (code)
      COND_AL:   ok = 1'b1;
      COND_Z:    ok = f.z;
      COND_NZ:   ok = !f.z;
      COND_GE:   ok = f.s ~^ f.o;
      COND_ZLT:  ok = f.z & (f.s ^ f.o);
      COND_GT:   ok = !f.z & (f.s ~^ f.o);
      COND_LT:   ok = f.s ^ f.o;
      COND_V:    ok = f.o;
      COND_BUSY: ok = busy;
      COND_MI:   ok = f.s;
      COND_PL:   ok = !f.s;
      COND_NC:   ok = !f.c;
      COND_LS:   ok = f.z | f.c;
      COND_HI:   ok = !(f.z | f.c);
      COND_CS:   ok = f.c;
      COND_NV:   ok = !f.o;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_branch(instr_t ins);
    return ins.op ==? 4'b010?;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Fetch/decode bundle between the core and the program-counter unit.
interface pc_unit_if #(parameter int ADDR_W = 16);
  import pc_unit_pkg::*;

  logic              advance;
  instr_t            instruction;
  csr_t              csr;
  logic [ADDR_W-1:0] src2;
  logic              busy;
  logic              call;
  logic              ret;
  logic              flush;
  logic [ADDR_W-1:0] flush_target;
  logic [ADDR_W-1:0] pc0;
  logic [ADDR_W-1:0] pc1;
  logic              taken;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output advance, instruction, csr, src2, busy, call, ret, flush, flush_target,
    input  pc0, pc1, taken, ras_overflow, ras_underflow
  );

  modport slave (
    input  advance, instruction, csr, src2, busy, call, ret, flush, flush_target,
    output pc0, pc1, taken, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: a full stack keeps accepting pushes by
// overwriting its oldest entry; push+pop together replaces the top in place.
module ras_stack #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              overflow_evt
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  top_idx;
  logic [CNT_W-1:0]  count;
  logic              do_pop;

  assign top_idx      = ptr - PTR_W'(1);
  assign top          = mem[top_idx];
  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(RAS_DEPTH));
  assign do_pop       = pop & !empty;
  assign overflow_evt = push & !do_pop & full;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && !do_pop) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (do_pop && !push) begin
      ptr   <= top_idx;
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[do_pop ? top_idx : ptr] <= din;
  end
endmodule

// File: rtl/pc_unit.sv
// Registered program-counter pair with branch resolution, return-address stack
// and an exception flush path that overrides normal fetch sequencing.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                RAS_DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input logic      clk,
  input logic      rst,
  pc_unit_if.slave bus
);
  instr_t            ins;
  cond_t             code;
  logic              taken;
  logic [ADDR_W-1:0] seq0;
  logic [ADDR_W-1:0] nxt_p0;
  logic              commit;
  logic              push;
  logic              pop;
  logic              underflow_evt;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              overflow_evt;
  logic [ADDR_W-1:0] pc0_p1;
  logic [ADDR_W-1:0] pc1_p1;
  logic              ovf_p1;
  logic              unf_p1;

  assign ins   = bus.instruction;
  assign code  = cond_t'({ins.op[0], ins.cc[2:0]});
  assign taken = is_branch(ins) & cond_eval(code, bus.csr, bus.busy);
  assign seq0  = pc1_p1 + ADDR_W'(ins.imm_valid);

  // A flush preempts any RAS activity, so decode side effects need advance without flush.
  assign commit        = bus.advance & !bus.flush;
  assign push          = commit & bus.call & (bus.ret | taken);
  assign pop           = commit & bus.ret & !ras_empty;
  assign underflow_evt = commit & bus.ret & ras_empty;

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .din         (seq0),
    .top         (ras_top),
    .empty       (ras_empty),
    .full        (ras_full),
    .overflow_evt(overflow_evt)
  );

  // Stage 0: choose the new pc0; pc1 always follows as pc0 + 1.
  always_comb begin
    nxt_p0 = seq0;
    if (bus.flush)                nxt_p0 = bus.flush_target;
    else if (bus.ret && !ras_empty) nxt_p0 = ras_top;
    else if (bus.ret)             nxt_p0 = seq0;
    else if (taken)               nxt_p0 = bus.src2;
  end

  // Stage 1: committed pointer pair and sticky stack flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc0_p1 <= RESET_VECTOR;
      pc1_p1 <= RESET_VECTOR + ADDR_W'(1);
      ovf_p1 <= 1'b0;
      unf_p1 <= 1'b0;
    end else begin
      if (bus.flush || bus.advance) begin
        pc0_p1 <= nxt_p0;
        pc1_p1 <= nxt_p0 + ADDR_W'(1);
      end
      if (overflow_evt)  ovf_p1 <= 1'b1;
      if (underflow_evt) unf_p1 <= 1'b1;
    end
  end

  assign bus.pc0           = pc0_p1;
  assign bus.pc1           = pc1_p1;
  assign bus.taken         = taken;
  assign bus.ras_overflow  = ovf_p1;
  assign bus.ras_underflow = unf_p1;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios with literal expectations plus random
// traffic compared every cycle against a queue-based reference model.
module tb_pc_unit;
  import pc_unit_pkg::*;

  localparam int          AW    = 16;
  localparam int          DEPTH = 8;
  localparam logic [15:0] RV    = 16'h0000;

  logic clk;
  logic rst;
  pc_unit_if #(.ADDR_W(AW)) bus ();

  pc_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: pointer pair, flags and the stack as a plain queue (oldest at front).
  logic [15:0] m_pc0, m_pc1;
  logic        m_ovf, m_unf;
  logic [15:0] m_ras[$];

  function automatic bit m_cond(logic [3:0] c, csr_t f, logic b);
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return f.z;
      4'd2:  return !f.z;
      4'd3:  return f.s == f.o;
      4'd4:  return f.z && (f.s != f.o);
      4'd5:  return !f.z && (f.s == f.o);
      4'd6:  return f.s != f.o;
      4'd7:  return f.o;
      4'd8:  return b;
      4'd9:  return f.s;
      4'd10: return !f.s;
      4'd11: return !f.c;
      4'd12: return f.z || f.c;
      4'd13: return !(f.z || f.c);
      4'd14: return f.c;
      default: return !f.o;
    endcase
  endfunction

  function automatic bit m_taken();
    logic [31:0] w;
    w = bus.instruction;
    return (w[31:29] == 3'b010) && m_cond({w[28], w[26:24]}, bus.csr, bus.busy);
  endfunction

  function automatic void m_push(logic [15:0] v);
    if (m_ras.size() == DEPTH) begin
      void'(m_ras.pop_front());
      m_ovf = 1'b1;
    end
    m_ras.push_back(v);
  endfunction

  always @(posedge clk) begin : model
    logic [15:0] s0;
    logic [15:0] tgt;
    logic        tk;
    logic [31:0] w;
    w  = bus.instruction;
    s0 = m_pc1 + (w[23] ? 16'd1 : 16'd0);
    tk = m_taken();
    if (rst) begin
      m_pc0 = RV; m_pc1 = RV + 16'd1;
      m_ras.delete();
      m_ovf = 1'b0; m_unf = 1'b0;
    end else if (bus.flush) begin
      m_pc0 = bus.flush_target; m_pc1 = bus.flush_target + 16'd1;
    end else if (bus.advance) begin
      tgt = s0;
      if (bus.ret) begin
        if (m_ras.size() > 0) begin
          tgt = m_ras[m_ras.size()-1];
          if (bus.call) m_ras[m_ras.size()-1] = s0;
          else void'(m_ras.pop_back());
        end else begin
          m_unf = 1'b1;
          if (bus.call) m_push(s0);
        end
      end else if (tk) begin
        tgt = bus.src2;
        if (bus.call) m_push(s0);
      end
      m_pc0 = tgt; m_pc1 = tgt + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc0", 32'(bus.pc0), 32'(m_pc0));
      check("pc1", 32'(bus.pc1), 32'(m_pc1));
      check("taken", 32'(bus.taken), 32'(m_taken()));
      check("ras_overflow", 32'(bus.ras_overflow), 32'(m_ovf));
      check("ras_underflow", 32'(bus.ras_underflow), 32'(m_unf));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(bit br, logic [3:0] code, bit imm);
    logic [31:0] w;
    w = '0;
    w[31:28] = br ? {3'b010, code[3]} : 4'b0000;
    w[26:24] = code[2:0];
    w[23]    = imm;
    return w;
  endfunction

  task automatic idle();
    bus.advance = 0; bus.instruction = '0; bus.csr = '0; bus.src2 = '0;
    bus.busy = 0; bus.call = 0; bus.ret = 0; bus.flush = 0; bus.flush_target = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_pc0", 32'(bus.pc0), 32'h0);
    check("rst_pc1", 32'(bus.pc1), 32'h1);
    check("rst_ovf", 32'(bus.ras_overflow), 32'h0);
    check("rst_unf", 32'(bus.ras_underflow), 32'h0);

    // Sequential stepping, then imm_valid skip.
    bus.advance = 1; bus.instruction = mk(0, 4'h0, 0);
    cyc(); check("seq1_pc0", 32'(bus.pc0), 32'h1); check("seq1_pc1", 32'(bus.pc1), 32'h2);
    cyc(); check("seq2_pc0", 32'(bus.pc0), 32'h2); check("seq2_pc1", 32'(bus.pc1), 32'h3);
    cyc(); cyc();
    bus.instruction = mk(0, 4'h0, 1);
    cyc(); check("imm_pc0", 32'(bus.pc0), 32'h6); check("imm_pc1", 32'(bus.pc1), 32'h7);

    // Code 0100 with Z=1,S=1,O=0: taken; stalled first, then committed.
    bus.advance = 0; bus.instruction = mk(1, 4'b0100, 0);
    bus.csr = '{z: 1'b1, s: 1'b1, o: 1'b0, c: 1'b0}; bus.src2 = 16'h0040;
    #1 check("zlt_taken", 32'(bus.taken), 32'h1);
    cyc(); check("stall_pc0", 32'(bus.pc0), 32'h6); check("stall_pc1", 32'(bus.pc1), 32'h7);
    bus.advance = 1;
    cyc(); check("br_pc0", 32'(bus.pc0), 32'h40); check("br_pc1", 32'(bus.pc1), 32'h41);

    // Code 1000 follows busy.
    bus.advance = 0; bus.csr = '0; bus.instruction = mk(1, 4'b1000, 0); bus.busy = 0;
    #1 check("busy0_taken", 32'(bus.taken), 32'h0);
    bus.busy = 1;
    #1 check("busy1_taken", 32'(bus.taken), 32'h1);
    bus.busy = 0;

    // Wrap-around of the sequential pair.
    bus.instruction = mk(0, 4'h0, 0); bus.flush = 1; bus.flush_target = 16'hFFFE;
    cyc(); bus.flush = 0; bus.advance = 1;
    cyc(); check("wrap_pc0", 32'(bus.pc0), 32'hFFFF); check("wrap_pc1", 32'(bus.pc1), 32'h0);

    // Nine calls from pc1 = 0x10..0x18 overflow an 8-deep stack.
    bus.advance = 0; bus.flush = 1; bus.flush_target = 16'h000F;
    cyc(); bus.flush = 0;
    bus.advance = 1; bus.call = 1; bus.instruction = mk(1, 4'h0, 0);
    for (int i = 0; i < 9; i++) begin
      bus.src2 = 16'h0010 + 16'(i);
      cyc();
      check("call_pc0", 32'(bus.pc0), 32'h10 + i);
      if (i == 7) check("ovf_before", 32'(bus.ras_overflow), 32'h0);
    end
    check("ovf_after", 32'(bus.ras_overflow), 32'h1);
    bus.call = 0; bus.ret = 1; bus.instruction = mk(0, 4'h0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("ret_pc0", 32'(bus.pc0), 32'h18 - i);
    end
    cyc();
    check("uf_pc0", 32'(bus.pc0), 32'h12); check("uf_pc1", 32'(bus.pc1), 32'h13);
    check("uf_flag", 32'(bus.ras_underflow), 32'h1);

    // Flush beats ret and leaves the stack alone; rst beats flush.
    bus.ret = 0; bus.call = 1; bus.instruction = mk(1, 4'h0, 0); bus.src2 = 16'h0300;
    cyc(); bus.call = 0;
    bus.advance = 0; bus.ret = 1; bus.flush = 1; bus.flush_target = 16'h1234;
    bus.instruction = mk(0, 4'h0, 0);
    cyc(); check("fl_pc0", 32'(bus.pc0), 32'h1234); check("fl_pc1", 32'(bus.pc1), 32'h1235);
    bus.flush = 0; bus.advance = 1;
    cyc(); check("fl_ras_kept", 32'(bus.pc0), 32'h13);
    rst = 1; bus.flush = 1; bus.flush_target = 16'h5555;
    cyc(); check("rst_fl_pc0", 32'(bus.pc0), 32'(RV)); check("rst_fl_pc1", 32'(bus.pc1), 32'(RV) + 1);
    check("rst_fl_unf", 32'(bus.ras_underflow), 32'h0);
    rst = 0; idle();

    // Full condition sweep (taken checked by the compare process each cycle).
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++)
        for (int b = 0; b < 2; b++) begin
          bus.instruction = mk(1, 4'(c), 0);
          bus.csr = csr_t'(4'(f));
          bus.busy = b[0];
          cyc();
        end

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] w;
      bit br;
      rst = ($urandom_range(0, 199) == 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.advance = ($urandom_range(0, 3) != 0);
      w = $urandom;
      br = ($urandom_range(0, 2) != 0);
      if (br) w[31:29] = 3'b010;
      else if (w[31:29] == 3'b010) w[31] = 1'b1;
      bus.instruction = w;
      bus.csr = csr_t'(4'($urandom));
      bus.busy = 1'($urandom);
      bus.call = ($urandom_range(0, 2) == 0);
      bus.ret = ($urandom_range(0, 3) == 0);
      bus.src2 = 16'($urandom);
      bus.flush_target = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                                      : 16'($urandom);
      cyc();
    end
    rst = 0; idle();
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
